// File: rtl/uart_pixel_decoder_pkg.sv
// Shared types and constants for the UART pixel decoder.
// Optional feature macro: UART_PIX_CRC_EN (adds the CHK state).
package uart_pixel_decoder_pkg;

  localparam logic [7:0] HDR0 = 8'hA5;
  localparam logic [7:0] HDR1 = 8'h5A;

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    PIX
`ifdef UART_PIX_CRC_EN
    ,
    CHK
`endif
  } state_e;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb12_t;

endpackage

// File: rtl/uart_pixel_decoder_timeout.sv
// Inter-byte gap counter: cleared by every accepted byte, counts while
// enabled, and flags expiry after TIMEOUT_CYCLES consecutive idle cycles.
module uart_pix_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Next count: a byte always wins over expiry, expiry restarts the count.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so
    // no path leaves it unassigned, which would infer a latch.
    expired = enable && !clear && (cnt_q == LAST);
    cnt_d   = cnt_q;
    if (clear || expired) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_pixel_decoder.sv
// UART byte stream to 12-bit pixel decoder with frame framing, timeout
// recovery and good/bad frame counters.
// Optional: define UART_PIX_CRC_EN to append and verify an XOR checksum byte.
module uart_pixel_decoder
  import uart_pixel_decoder_pkg::*;
#(
  parameter int unsigned PANEL_ROWS     = 64,
  parameter int unsigned PANEL_COLS     = 64,
  parameter int unsigned COLOR_DEPTH    = 4,
  parameter int unsigned TIMEOUT_CYCLES = 500000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     rx_valid,
  output logic                     rx_ready,
  input  logic [7:0]               rx_data,
  output logic                     pix_sync,
  output logic                     pix_valid,
  output logic [3*COLOR_DEPTH-1:0] pix_rgb,
  output logic                     frame_done,
  output logic                     frame_err,
  output logic [15:0]              frame_cnt,
  output logic [7:0]               err_cnt
);

  localparam int unsigned NPIX = PANEL_ROWS * PANEL_COLS;
  localparam int unsigned PCW  = $clog2(NPIX) + 1;
  localparam logic [PCW-1:0] LAST_PIX = PCW'(NPIX - 1);

  if (COLOR_DEPTH != 4) begin : g_bad_depth
    $error("uart_pixel_decoder: COLOR_DEPTH must be 4");
  end

  state_e         state_q, state_d;
  logic [1:0]     phase_q, phase_d;
  logic [PCW-1:0] pix_cnt_q, pix_cnt_d;
  logic [7:0]     byte_q, byte_d;
  rgb12_t         pix_rgb_q, pix_rgb_d;
  logic           pix_sync_q, pix_sync_d;
  logic           pix_valid_q, pix_valid_d;
  logic           frame_done_q, frame_done_d;
  logic           frame_err_q, frame_err_d;
  logic [15:0]    frame_cnt_q, frame_cnt_d;
  logic [7:0]     err_cnt_q, err_cnt_d;
  logic           rx_ready_q;
  logic           accept, expired, in_frame;
`ifdef UART_PIX_CRC_EN
  logic [7:0]     crc_q, crc_d;
`endif

  assign accept = rx_valid && rx_ready_q;

  uart_pix_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (accept),
    .enable  (state_q != IDLE),
    .expired (expired)
  );

  // Framing FSM, payload unpacking and status pulses.
  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    pix_cnt_d    = pix_cnt_q;
    byte_d       = byte_q;
    pix_rgb_d    = pix_rgb_q;
    pix_sync_d   = 1'b0;
    pix_valid_d  = 1'b0;
    frame_done_d = 1'b0;
    frame_err_d  = 1'b0;
`ifdef UART_PIX_CRC_EN
    crc_d        = crc_q;
    in_frame     = (state_q == PIX) || (state_q == CHK);
`else
    in_frame     = (state_q == PIX);
`endif
    if (accept) begin
      case (state_q)
        IDLE: if (rx_data == HDR0) state_d = HDR;
        HDR: begin
          if (rx_data == HDR1) begin
            state_d    = PIX;
            pix_sync_d = 1'b1;
            phase_d    = 2'd0;
            pix_cnt_d  = '0;
`ifdef UART_PIX_CRC_EN
            crc_d      = '0;
`endif
          end else if (rx_data != HDR0) begin
            state_d = IDLE;
          end
        end
        PIX: begin
          byte_d = rx_data;
`ifdef UART_PIX_CRC_EN
          crc_d  = crc_q ^ rx_data;
`endif
          case (phase_q)
            2'd0: phase_d = 2'd1;
            2'd1: begin
              phase_d     = 2'd2;
              pix_valid_d = 1'b1;
              pix_rgb_d   = {byte_q, rx_data[7:4]};
              pix_cnt_d   = pix_cnt_q + PCW'(1);
            end
            default: begin
              phase_d     = 2'd0;
              pix_valid_d = 1'b1;
              pix_rgb_d   = {byte_q[3:0], rx_data};
              pix_cnt_d   = pix_cnt_q + PCW'(1);
              if (pix_cnt_q == LAST_PIX) begin
`ifdef UART_PIX_CRC_EN
                state_d      = CHK;
`else
                state_d      = IDLE;
                frame_done_d = 1'b1;
`endif
              end
            end
          endcase
        end
`ifdef UART_PIX_CRC_EN
        CHK: begin
          state_d      = IDLE;
          frame_done_d = (rx_data == crc_q);
          frame_err_d  = (rx_data != crc_q);
        end
`endif
        default: state_d = IDLE;
      endcase
    end else if (expired) begin
      state_d     = IDLE;
      frame_err_d = in_frame;
    end

    frame_cnt_d = frame_cnt_q + 16'(frame_done_d);
    err_cnt_d   = (frame_err_d && (err_cnt_q != 8'hFF)) ? err_cnt_q + 8'd1 : err_cnt_q;
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      phase_q      <= '0;
      pix_cnt_q    <= '0;
      byte_q       <= '0;
      pix_rgb_q    <= '0;
      pix_sync_q   <= 1'b0;
      pix_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
      frame_cnt_q  <= '0;
      err_cnt_q    <= '0;
      rx_ready_q   <= 1'b0;
`ifdef UART_PIX_CRC_EN
      crc_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      pix_cnt_q    <= pix_cnt_d;
      byte_q       <= byte_d;
      pix_rgb_q    <= pix_rgb_d;
      pix_sync_q   <= pix_sync_d;
      pix_valid_q  <= pix_valid_d;
      frame_done_q <= frame_done_d;
      frame_err_q  <= frame_err_d;
      frame_cnt_q  <= frame_cnt_d;
      err_cnt_q    <= err_cnt_d;
      rx_ready_q   <= 1'b1;
`ifdef UART_PIX_CRC_EN
      crc_q        <= crc_d;
`endif
    end
  end

  assign rx_ready   = rx_ready_q;
  assign pix_sync   = pix_sync_q;
  assign pix_valid  = pix_valid_q;
  assign pix_rgb    = pix_rgb_q;
  assign frame_done = frame_done_q;
  assign frame_err  = frame_err_q;
  assign frame_cnt  = frame_cnt_q;
  assign err_cnt    = err_cnt_q;

endmodule
